// File: rtl/store_align_unit.sv
// store_align_unit: store path of the core. Narrows a register value to
// SB/SH/SW width, lane-aligns it onto a 32-bit word-addressed memory port,
// generates byte strobes and splits word-crossing stores into two beats.
module store_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_data,
  input  logic [2:0]  i_req_funct3,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t      r_state;
  logic        r_started;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_mask;

  logic [3:0]  w_in_mask;
  logic        w_in_legal;
  logic [7:0]  w_in_m8;
  logic        w_in_cross;
  logic [31:0] w_in_bytes;
  logic        w_accept;

  logic [7:0]  w_m8;
  logic [63:0] w_d64;
  logic [31:0] w_beat0_addr;
  logic [31:0] w_beat1_addr;

  // Decode the incoming request; only feeds the state/latch registers.
  always_comb begin
    w_in_mask  = 4'b0000;
    w_in_legal = 1'b0;
    case (i_req_funct3)
      3'b000: begin w_in_mask = 4'b0001; w_in_legal = 1'b1; end
      3'b001: begin w_in_mask = 4'b0011; w_in_legal = 1'b1; end
      3'b010: begin w_in_mask = 4'b1111; w_in_legal = 1'b1; end
      default: begin w_in_mask = 4'b0000; w_in_legal = 1'b0; end
    endcase
    w_in_m8    = {4'b0000, w_in_mask} << i_req_addr[1:0];
    w_in_cross = |w_in_m8[7:4];
    w_in_bytes = {{8{w_in_mask[3]}}, {8{w_in_mask[2]}},
                  {8{w_in_mask[1]}}, {8{w_in_mask[0]}}};
  end

  assign w_accept = o_req_ready & i_req_valid;

  // Lane placement derived from the latched (already narrowed) request.
  assign w_m8         = {4'b0000, r_mask} << r_addr[1:0];
  assign w_d64        = {32'b0, r_data} << {r_addr[1:0], 3'b000};
  assign w_beat0_addr = {r_addr[31:2], 2'b00};
  assign w_beat1_addr = w_beat0_addr + 32'd4;

  // Store sequencer: latch the request in IDLE, then walk the beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
      r_addr    <= 32'b0;
      r_data    <= 32'b0;
      r_mask    <= 4'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr <= i_req_addr;
            r_data <= i_req_data & w_in_bytes;
            r_mask <= w_in_mask;
            if (!w_in_legal)
              r_state <= S_ERROR;
            else if (w_in_cross && !ALLOW_MISALIGNED)
              r_state <= S_ERROR;
            else
              r_state <= S_BEAT0;
          end
        end
        S_BEAT0: begin
          if (i_mem_ready)
            r_state <= (|w_m8[7:4]) ? S_BEAT1 : S_FINISH;
        end
        S_BEAT1: begin
          if (i_mem_ready)
            r_state <= S_FINISH;
        end
        S_FINISH: r_state <= S_IDLE;
        S_ERROR:  r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Output decode from state and latched registers only.
  always_comb begin
    o_req_ready = r_started && (r_state == S_IDLE);
    o_mem_valid = 1'b0;
    o_mem_addr  = 32'b0;
    o_mem_wdata = 32'b0;
    o_mem_wstrb = 4'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      S_BEAT0: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = w_beat0_addr;
        o_mem_wdata = w_d64[31:0];
        o_mem_wstrb = w_m8[3:0];
      end
      S_BEAT1: begin
        o_mem_valid = 1'b1;
        o_mem_addr  = w_beat1_addr;
        o_mem_wdata = w_d64[63:32];
        o_mem_wstrb = w_m8[7:4];
      end
      S_FINISH: o_done = 1'b1;
      S_ERROR:  o_err  = 1'b1;
      default: ;
    endcase
  end

endmodule
